// File: rtl/crank_position_decoder.sv
// Missing-tooth crank wheel decoder: filters the raw CKP pin, measures tooth
// periods, locks onto the gap and publishes tooth index, revolution and sync.
module crank_position_decoder #(
  parameter int TEETH         = 36,
  parameter int MISSING       = 1,
  parameter int FILTER_CYCLES = 4,
  parameter int PERIOD_W      = 20,
  parameter int STALL_CYCLES  = 1000000,
  localparam int IDX_W        = $clog2(TEETH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                on,
  input  logic                ckp,
  output logic                crank_tick,
  output logic                crank_changed,
  output logic [IDX_W-1:0]    tooth_idx,
  output logic                rev,
  output logic                synced,
  output logic                sync_lost,
  output logic [PERIOD_W-1:0] tooth_period
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TEETH - MISSING - 1);
  localparam logic [PERIOD_W-1:0] STALL = PERIOD_W'(STALL_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEEK = 2'd1;
  localparam logic [1:0] S_VER  = 2'd2;
  localparam logic [1:0] S_SYN  = 2'd3;

  logic s1_q, s2_q;
  logic filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic fprev_q, edge_q;

  logic [1:0] st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic rev_q, rev_d;
  logic syn_q, syn_d;
  logic seen_q, seen_d;
  logic tick_q, tick_d;
  logic lost_q, lost_d;
  logic chg_q, chg_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;

  logic [PERIOD_W+1:0] cnt2, per3;
  logic gap, stall;
  logic [IDX_W:0] out_d, out_q;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s2_q != filt_q) begin
      if (fcnt_q == FLAST) filt_d = s2_q;
      else fcnt_d = fcnt_q + FW'(1);
    end
  end

  // cnt_q at the edge is the new period; per_q still holds the previous one
  assign cnt2  = {1'b0, cnt_q, 1'b0};
  assign per3  = {2'b00, per_q} + {1'b0, per_q, 1'b0};
  assign gap   = cnt2 > per3;
  assign stall = (cnt_q == STALL);

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    rev_d  = rev_q;
    syn_d  = syn_q;
    seen_d = seen_q;
    tick_d = 1'b0;
    lost_d = 1'b0;
    per_d  = per_q;
    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
    if (!on || st_q == S_IDLE) begin
      st_d   = on ? S_SEEK : S_IDLE;
      idx_d  = '0;
      rev_d  = 1'b0;
      syn_d  = 1'b0;
      seen_d = 1'b0;
      per_d  = '0;
      cnt_d  = '0;
    end else if (edge_q) begin
      per_d = cnt_q;
      cnt_d = PERIOD_W'(1);
      unique case (1'b1)
        (st_q == S_SEEK): begin
          seen_d = 1'b1;
          if (seen_q && gap) begin
            st_d  = S_VER;
            idx_d = '0;
          end
        end
        (st_q == S_VER): begin
          if (gap) begin
            idx_d = '0;
            if (idx_q == LAST) begin
              st_d  = S_SYN;
              syn_d = 1'b1;
            end
          end else if (idx_q == LAST) begin
            st_d = S_SEEK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        (st_q == S_SYN): begin
          if (gap == (idx_q == LAST)) begin
            tick_d = 1'b1;
            idx_d  = gap ? '0 : idx_q + IDX_W'(1);
            rev_d  = rev_q ^ gap;
          end else begin
            st_d   = S_SEEK;
            syn_d  = 1'b0;
            idx_d  = '0;
            rev_d  = 1'b0;
            lost_d = 1'b1;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end else if (stall) begin
      st_d   = S_SEEK;
      lost_d = (st_q == S_SYN);
      syn_d  = 1'b0;
      idx_d  = '0;
      rev_d  = 1'b0;
      seen_d = 1'b0;
      per_d  = '0;
    end
  end

  assign out_d = syn_d ? {rev_d, idx_d} : '0;
  assign out_q = {rev, tooth_idx};
  assign chg_d = on & (out_d != out_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      filt_q  <= 1'b0;
      fcnt_q  <= '0;
      fprev_q <= 1'b0;
      edge_q  <= 1'b0;
      st_q    <= S_IDLE;
      idx_q   <= '0;
      rev_q   <= 1'b0;
      syn_q   <= 1'b0;
      seen_q  <= 1'b0;
      tick_q  <= 1'b0;
      lost_q  <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
    end else begin
      s1_q    <= ckp;
      s2_q    <= s1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      fprev_q <= filt_q;
      edge_q  <= filt_q & ~fprev_q;
      st_q    <= st_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
      syn_q   <= syn_d;
      seen_q  <= seen_d;
      tick_q  <= tick_d;
      lost_q  <= lost_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
    end
  end

  assign crank_tick    = tick_q;
  assign crank_changed = chg_q;
  assign sync_lost     = lost_q;
  assign synced        = syn_q;
  assign tooth_idx     = syn_q ? idx_q : '0;
  assign rev           = syn_q & rev_q;
  assign tooth_period  = per_q;

endmodule
